md_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller for the pipeline's execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and computes the product or quotient/remainder from the EX operands.
- Holds the result for a fixed latency, then commits it to the architectural HI/LO registers.
- Drives busy and stall to the hazard unit, so the pipeline can share the single MD resource with correct ordering.

---
 rtl/md_defs.sv | 28 ++
 rtl/md_calc.sv | 64 ++++++
 rtl/md_ctrl.sv | 104 ++++++++++
 tb/tb_md_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared command codes, widths and latencies for the multiply/divide unit.
package md_defs;

   localparam int MD_WIDTH = 32;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_NOP7  = 3'd7
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   function automatic logic is_arith(input logic [2:0] op);
      return (op >= 3'd1) && (op <= 3'd4);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result for one MD command; holds hi/lo on divide by zero.
module md_calc
   import md_defs::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
   logic        [2*WIDTH-1:0] prod_u;
   logic signed [WIDTH-1:0]   div_bs, quo_s, rem_s;
   logic        [WIDTH-1:0]   div_bu, quo_u, rem_u;
   logic                      b_zero, ovf;

   always_comb begin
      a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
      b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
      prod_s = a_sx * b_sx;
      prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
      b_zero = (src_b == '0);
      ovf    = (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);
      // Divisors are steered to 1 in the cases that are resolved separately,
      // so the dividers never see an undefined operation.
      div_bs = (b_zero || ovf) ? WIDTH'(1) : src_b;
      div_bu = b_zero ? WIDTH'(1) : src_b;
      quo_s  = $signed(src_a) / div_bs;
      rem_s  = $signed(src_a) % div_bs;
      quo_u  = src_a / div_bu;
      rem_u  = src_a % div_bu;

      res_hi = hi;
      res_lo = lo;
      case (md_op)
         MD_MULT:  {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
         MD_DIV: begin
            if (ovf) begin
               res_hi = '0;
               res_lo = src_a;
            end else if (!b_zero) begin
               res_hi = rem_s;
               res_lo = quo_s;
            end
         end
         MD_DIVU: begin
            if (!b_zero) begin
               res_hi = rem_u;
               res_lo = quo_u;
            end
         end
         MD_MTHI:  res_hi = src_a;
         MD_MTLO:  res_lo = src_a;
         default: ;
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle multiply/divide controller: latches the result at accept,
// commits it to HI/LO after a fixed latency, and requests pipeline stalls.
//
//   state   | meaning
//   ST_IDLE | no operation in flight; accepts MD commands and MTHI/MTLO
//   ST_RUN  | result held in tmp_hi/tmp_lo, cnt counting down to commit
module md_ctrl
   import md_defs::*;
#(
   parameter int WIDTH       = MD_WIDTH,
   parameter int MULT_CYCLES = MULT_LAT,
   parameter int DIV_CYCLES  = DIV_LAT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             d_is_md,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             start;

   md_calc #(.WIDTH(WIDTH)) u_calc (
      .md_op  (md_op),
      .src_a  (src_a),
      .src_b  (src_b),
      .hi     (hi_q),
      .lo     (lo_q),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         tmp_hi_q <= '0;
         tmp_lo_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         tmp_hi_q <= tmp_hi_d;
         tmp_lo_q <= tmp_lo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      tmp_hi_d = tmp_hi_q;
      tmp_lo_d = tmp_lo_q;
      case (state_q)
         ST_IDLE: begin
            if (op_valid && is_arith(md_op)) begin
               tmp_hi_d = res_hi;
               tmp_lo_d = res_lo;
               cnt_d    = (md_op == MD_MULT || md_op == MD_MULTU) ?
                          CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               state_d  = ST_RUN;
            end else if (op_valid && (md_op == MD_MTHI || md_op == MD_MTLO)) begin
               hi_d = res_hi;
               lo_d = res_lo;
            end
         end
         ST_RUN: begin
            // Commands arriving here are ignored; the stall keeps them out.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = tmp_hi_q;
               lo_d    = tmp_lo_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy  = (state_q == ST_RUN);
   assign start = op_valid && is_arith(md_op) && !busy;
   assign stall = d_is_md && (busy || start);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed and randomized bench for md_ctrl against an arithmetic reference model.
module tb_md_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] src_a = '0;
   logic [31:0] src_b = '0;
   logic        d_is_md = 1'b0;
   logic        busy, stall;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   // Reference model: remaining busy cycles plus architectural and pending values.
   int          m_left = 0;
   logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

   md_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .op_valid (op_valid),
      .md_op    (md_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .d_is_md  (d_is_md),
      .busy     (busy),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
      longint      p, q, r;
      logic [63:0] pu;
      rh = m_hi;
      rl = m_lo;
      case (op)
         3'd1: begin
            p = longint'($signed(a)) * longint'($signed(b));
            {rh, rl} = p;
         end
         3'd2: begin
            pu = {32'b0, a} * {32'b0, b};
            {rh, rl} = pu;
         end
         3'd3: if (b != 0) begin
            q  = longint'($signed(a)) / longint'($signed(b));
            r  = longint'($signed(a)) % longint'($signed(b));
            rh = r[31:0];
            rl = q[31:0];
         end
         3'd4: if (b != 0) begin
            rh = a % b;
            rl = a / b;
         end
         default: ;
      endcase
   endfunction

   task automatic cyc(input logic r, input logic v, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic d);
      logic exp_stall;
      logic [31:0] rh, rl;
      @(negedge clk);
      reset = r; op_valid = v; md_op = op; src_a = a; src_b = b; d_is_md = d;
      #1;
      exp_stall = d && ((m_left > 0) || (v && op >= 3'd1 && op <= 3'd4));
      chk("stall", stall, exp_stall);
      if (r) begin
         m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (v) begin
         if (op >= 3'd1 && op <= 3'd4) begin
            calc(op, a, b, rh, rl);
            m_phi  = rh;
            m_plo  = rl;
            m_left = (op <= 3'd2) ? 5 : 10;
         end else if (op == 3'd5) m_hi = a;
         else if (op == 3'd6) m_lo = a;
      end
      @(posedge clk);
      #1;
      chk("busy", busy, (m_left > 0));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   endtask

   task automatic idle(input int n, input logic d);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, d);
   endtask

   initial begin
      logic        r, v, d;
      logic [2:0]  op;
      logic [31:0] a, b;

      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);

      cyc(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
      idle(5, 1'b1);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFF1);

      cyc(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
      idle(5, 1'b1);
      chk("multu_hi", hi, 32'h0000_0001);
      chk("multu_lo", lo, 32'hFFFF_FFFE);
      cyc(1'b0, 1'b1, 3'd4, 32'd7, 32'd2, 1'b1);
      idle(10, 1'b1);
      chk("divu_hi", hi, 32'd1);
      chk("divu_lo", lo, 32'd3);

      cyc(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
      idle(10, 1'b1);
      chk("div_hi", hi, 32'hFFFF_FFFF);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      cyc(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      idle(10, 1'b1);
      chk("div_ovf_hi", hi, 32'h0);
      chk("div_ovf_lo", lo, 32'h8000_0000);

      cyc(1'b0, 1'b1, 3'd5, 32'h1234_5678, 32'h0, 1'b1);
      chk("mthi", hi, 32'h1234_5678);
      cyc(1'b0, 1'b1, 3'd6, 32'hCAFE_BABE, 32'h0, 1'b1);
      chk("mtlo", lo, 32'hCAFE_BABE);
      cyc(1'b0, 1'b1, 3'd3, 32'd5, 32'd0, 1'b1);
      idle(10, 1'b1);
      chk("div0_hi", hi, 32'h1234_5678);
      chk("div0_lo", lo, 32'hCAFE_BABE);

      cyc(1'b0, 1'b1, 3'd7, 32'h1111_1111, 32'h0, 1'b1);
      cyc(1'b0, 1'b1, 3'd0, 32'h2222_2222, 32'h0, 1'b1);
      chk("noop_hi", hi, 32'h1234_5678);

      cyc(1'b0, 1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
      idle(5, 1'b0);
      chk("nostall_lo", lo, 32'd42);

      cyc(1'b0, 1'b1, 3'd1, 32'd3, 32'd4, 1'b1);
      idle(2, 1'b1);
      cyc(1'b0, 1'b1, 3'd1, 32'd100, 32'd100, 1'b1);
      cyc(1'b0, 1'b1, 3'd4, 32'd9, 32'd3, 1'b1);
      idle(3, 1'b1);
      chk("inject_hi", hi, 32'd0);
      chk("inject_lo", lo, 32'd12);

      cyc(1'b0, 1'b1, 3'd3, 32'd100, 32'd7, 1'b1);
      idle(2, 1'b1);
      cyc(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_lo", lo, 32'h0);
      idle(12, 1'b1);
      chk("rst_nolate_hi", hi, 32'h0);
      chk("rst_nolate_lo", lo, 32'h0);

      for (int i = 0; i < 500; i++) begin
         r  = ($urandom_range(99) == 0);
         v  = ($urandom_range(2) != 0);
         op = 3'($urandom_range(7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(9))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(9));
            default: ;
         endcase
         d = 1'($urandom_range(1));
         cyc(r, v, op, a, b, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
